d_ff: RTL and testbench



---
 rtl/d_ff_pkg.sv | 8 +
 rtl/d_ff_stage.sv | 20 ++
 rtl/d_ff.sv | 41 ++++
 tb/tb_d_ff.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// Shared constants for the d_ff register primitive.
// Legal parameter ranges are checked by the top at elaboration.
package d_ff_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_DEPTH = 16;

endpackage

// File: rtl/d_ff_stage.sv
// Single WIDTH-bit register stage with synchronous active-high clear.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // clr wins over d, so a clear edge never lets data through.
    always_ff @(posedge clk) begin
        if (clr) q <= RESET_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/d_ff.sv
// Synchronous-clear D register with DEPTH cascaded stages between D and q.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("d_ff: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("d_ff: DEPTH %0d outside 1..%0d", DEPTH, MAX_DEPTH);
    end

    // chain[0] is the input, chain[k+1] the output of stage k.
    logic [DEPTH:0][WIDTH-1:0] chain;

    assign chain[0] = D;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        d_ff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk (clk),
            .clr (clr),
            .d   (chain[k]),
            .q   (chain[k+1])
        );
    end

    assign q = chain[DEPTH];

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: default 1-bit instance and an 8-bit, 3-deep pipeline.
module tb_d_ff;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       clr1 = 1'b0, d1 = 1'b0, q1;
    logic       clr8 = 1'b0;
    logic [7:0] d8 = 8'h00, q8;

    always #20 clk = ~clk;

    d_ff u_dff1 (
        .clk (clk),
        .clr (clr1),
        .D   (d1),
        .q   (q1)
    );

    d_ff #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV8)) u_dff8 (
        .clk (clk),
        .clr (clr8),
        .D   (d8),
        .q   (q8)
    );

    int vec = 0, bad = 0;

    // Reference model: a log of what was presented at every rising edge.
    int         n = 0;
    logic       h_d1[$], h_c1[$], h_c8[$];
    logic [7:0] h_d8[$];

    always @(posedge clk) begin
        h_d1.push_back(d1);
        h_c1.push_back(clr1);
        h_d8.push_back(d8);
        h_c8.push_back(clr8);
        n++;
    end

    // 1-bit, depth 1: q after the latest edge is that edge's D unless cleared.
    function automatic logic model1();
        int k = n - 1;
        if (h_c1[k]) return 1'b0;
        return h_d1[k];
    endfunction

    // 3-deep: q shows D from two edges earlier, unless any clear edge
    // occurred at or after that sample edge.
    function automatic logic [7:0] model8();
        int k   = n - 1;
        int src = k - 2;
        int lo  = (src < 0) ? 0 : src;
        for (int j = lo; j <= k; j++)
            if (h_c8[j]) return RV8;
        if (src < 0) return 8'bx;
        return h_d8[src];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup();
        clr8 = 1'b0;
        d8   = 8'h3C;
        step();
        clr8 = 1'b1;
        step();
        vec++;
        if (q8 !== RV8) begin
            bad++;
            $display("FAIL powerup_first_clear: q8=%h expected %h", q8, RV8);
        end
    endtask

    task automatic test_reset();
        clr1 = 1'b1;
        d1   = 1'b0;
        clr8 = 1'b1;
        d8   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            vec++;
            if (q1 !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold q1: edge %0d q=%b expected 0", i, q1);
            end
            vec++;
            if (q8 !== RV8) begin
                bad++;
                $display("FAIL reset_hold q8: edge %0d q=%h expected %h", i, q8, RV8);
            end
        end
        d1 = 1'b1;
        d8 = 8'hFF;
        step();
        vec++;
        if (q1 !== 1'b0) begin
            bad++;
            $display("FAIL clear_dominates q1: q=%b expected 0", q1);
        end
        vec++;
        if (q8 !== RV8) begin
            bad++;
            $display("FAIL clear_dominates q8: q=%h expected %h", q8, RV8);
        end
    endtask

    task automatic test_capture();
        logic pat[3] = '{1'b1, 1'b0, 1'b1};
        clr1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d1 = pat[i];
            step();
            vec++;
            if (q1 !== pat[i] || q1 !== model1()) begin
                bad++;
                $display("FAIL capture[%0d]: q=%b expected %b", i, q1, pat[i]);
            end
        end
        d1 = 1'b0;
        #15;
        vec++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL no_change_between_edges: q=%b expected 1", q1);
        end
        d1 = 1'b1;
        step();
    endtask

    task automatic test_midclear();
        d1   = 1'b1;
        clr1 = 1'b1;
        step();
        vec++;
        if (q1 !== 1'b0) begin
            bad++;
            $display("FAIL midclear_assert: q=%b expected 0", q1);
        end
        clr1 = 1'b0;
        step();
        vec++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL midclear_release: q=%b expected 1", q1);
        end
    endtask

    task automatic test_glitch();
        d1 = 1'b1;
        step();
        #10 d1 = 1'b0;
        #5  d1 = 1'b1;
        vec++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL glitch_between_edges: q=%b expected 1", q1);
        end
        step();
        vec++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL glitch_next_edge: q=%b expected 1", q1);
        end
    endtask

    task automatic test_pipeline();
        logic [7:0] exp[5] = '{RV8, RV8, 8'h01, 8'h02, 8'h03};
        logic [7:0] din[5] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03};
        clr8 = 1'b1;
        step();
        vec++;
        if (q8 !== RV8) begin
            bad++;
            $display("FAIL pipe_clear: q=%h expected %h", q8, RV8);
        end
        clr8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d8 = din[i];
            step();
            vec++;
            if (q8 !== exp[i] || q8 !== model8()) begin
                bad++;
                $display("FAIL pipe_latency[%0d]: q=%h expected %h", i, q8, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            d1   = 1'($urandom);
            d8   = 8'($urandom);
            clr1 = ($urandom_range(0, 7) == 0);
            clr8 = ($urandom_range(0, 9) == 0);
            step();
            vec++;
            if (q1 !== model1()) begin
                bad++;
                $display("FAIL random q1 [%0d]: q=%b expected %b", i, q1, model1());
            end
            vec++;
            if (q8 !== model8()) begin
                bad++;
                $display("FAIL random q8 [%0d]: q=%h expected %h", i, q8, model8());
            end
        end
    endtask

    initial begin
        test_powerup();
        test_reset();
        test_capture();
        test_midclear();
        test_glitch();
        test_pipeline();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
